fp_add_seq: RTL and testbench

//   Multi-cycle IEEE-754 single-precision adder/subtractor. It consumes the

---
 rtl/fp_add_seq_if.sv | 24 ++
 rtl/fp_add_seq.sv | 173 +++++++++++++++++
 tb/tb_fp_add_seq.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/fp_add_seq_if.sv
// fp_add_seq_if: operand/result handshake bundle for fp_add_seq
//   in_valid/in_ready, a, b, sub   : operation request (master -> slave)
//   out_valid/out_ready            : result handshake (slave -> master)
//   result, overflow, underflow    : result word and exception flags
interface fp_add_seq_if #(parameter int W = 32);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         overflow;
    logic         underflow;
    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, result, overflow, underflow
    );
    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, result, overflow, underflow
    );
endinterface

// File: rtl/fp_add_seq.sv
// fp_add_seq: multi-cycle fixed-latency IEEE-754 adder/subtractor
//   clk : rising-edge clock
//   clr : asynchronous active-high reset
//   io  : slave side of fp_add_seq_if (operands in, result and flags out)
module fp_add_seq #(
    parameter int EXP_W      = 8,
    parameter int MAN_W      = 23,
    parameter int ROUND_MODE = 0
) (
    input logic         clk,
    input logic         clr,
    fp_add_seq_if.slave io
);
    localparam int W   = 1 + EXP_W + MAN_W;
    localparam int MW  = MAN_W + 4;
    localparam int LZW = $clog2(MW + 1);
    localparam int XW  = EXP_W + 2;
    localparam logic [EXP_W-1:0] EMAX = '1;
    localparam logic [EXP_W-1:0] EMAX_M1 = EMAX - 1'b1;
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND, DONE} state_t;
    state_t state, nxt;

    logic [W-1:0]          op_a, op_b, spec_r, res_v, pack, ovf_v;
    logic                  sign_r, eff_sub, special, zero_r;
    logic [EXP_W-1:0]      exp_r;
    logic [MW-1:0]         ma, mb, mn, nm;
    logic [MW:0]           sum_r, sum;
    logic signed [XW-1:0]  en, ne, fe;
    logic [W-1:0]          result_r;
    logic                  overflow_r, underflow_r;

    logic                  sa, sb, za, zb, ia, ib, na, nb, swap, spec, big_s;
    logic [EXP_W-1:0]      ea, eb, big_e, sml_e, d;
    logic [MAN_W-1:0]      fa, fb, big_f, sml_f;
    logic [LZW-1:0]        sh, lz;
    logic [MW-1:0]         sml_m, sml_sh, mask;
    logic [W-1:0]          spec_v;
    logic                  inc, uf, of;
    logic [MAN_W+1:0]      mr;
    logic [MAN_W-1:0]      frac;

    assign io.in_ready  = state == IDLE;
    assign io.out_valid = state == DONE;
    assign io.result    = result_r;
    assign io.overflow  = overflow_r;
    assign io.underflow = underflow_r;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) state <= IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = io.in_valid ? ALIGN : IDLE;
            ALIGN:   nxt = ADD;
            ADD:     nxt = NORM;
            NORM:    nxt = ROUND;
            ROUND:   nxt = DONE;
            DONE:    nxt = io.out_ready ? IDLE : DONE;
            default: nxt = IDLE;
        endcase
    end

    // Unpack, classify, order by magnitude and align the smaller operand.
    // Denormals count as zero; zero/Inf/NaN operands bypass the datapath.
    always_comb begin
        {sa, ea, fa} = op_a;
        {sb, eb, fb} = op_b;
        za = ea == '0;
        zb = eb == '0;
        ia = ea == EMAX && fa == '0;
        ib = eb == EMAX && fb == '0;
        na = ea == EMAX && fa != '0;
        nb = eb == EMAX && fb != '0;
        swap  = op_b[W-2:0] > op_a[W-2:0];
        big_s = swap ? sb : sa;
        big_e = swap ? eb : ea;
        big_f = swap ? fb : fa;
        sml_e = swap ? ea : eb;
        sml_f = swap ? fa : fb;
        d  = big_e - sml_e;
        // Beyond MW-1 the hidden bit would only feed sticky anyway.
        sh = (int'(d) > MW - 1) ? LZW'(MW - 1) : LZW'(d);
        sml_m  = {1'b1, sml_f, 3'b000};
        mask   = ~({MW{1'b1}} << sh);
        sml_sh = (sml_m >> sh) | {{(MW-1){1'b0}}, |(sml_m & mask)};
        spec   = na | nb | ia | ib | za | zb;
        spec_v = (na | nb | (ia & ib & (sa != sb))) ? QNAN :
                 ia ? op_a :
                 ib ? op_b :
                 (za & zb) ? {sa & sb, {(W-1){1'b0}}} :
                 za ? op_b : op_a;
    end

    assign sum = eff_sub ? {1'b0, ma} - {1'b0, mb} : {1'b0, ma} + {1'b0, mb};

    // Leading-zero count below the carry bit; the highest set bit wins.
    always_comb begin
        lz = '0;
        for (int i = 0; i < MW; i++)
            if (sum_r[i]) lz = LZW'(MW - 1 - i);
        nm = sum_r[MW] ? {sum_r[MW:2], sum_r[1] | sum_r[0]} : sum_r[MW-1:0] << lz;
        ne = sum_r[MW] ? XW'(exp_r) + XW'(1) : XW'(exp_r) - XW'(lz);
    end

    // mn[2:0] are guard, round and sticky; mn[3] is the result LSB.
    always_comb begin
        inc  = (ROUND_MODE == 0) && mn[2] && (mn[1] | mn[0] | mn[3]);
        mr   = {1'b0, mn[MW-1:3]} + (MAN_W+2)'(inc);
        fe   = en + XW'(mr[MAN_W+1]);
        frac = mr[MAN_W+1] ? mr[MAN_W:1] : mr[MAN_W-1:0];
        uf   = int'(en) <= 0;
        of   = int'(fe) >= (1 << EXP_W) - 1;
        pack = {sign_r, fe[EXP_W-1:0], frac};
        ovf_v = (ROUND_MODE != 0) ? {sign_r, EMAX_M1, {MAN_W{1'b1}}} : {sign_r, EMAX, {MAN_W{1'b0}}};
        res_v = special ? spec_r :
                zero_r  ? '0 :
                uf      ? {sign_r, {(W-1){1'b0}}} :
                of      ? ovf_v : pack;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            op_a        <= '0;
            op_b        <= '0;
            spec_r      <= '0;
            special     <= 1'b0;
            sign_r      <= 1'b0;
            eff_sub     <= 1'b0;
            exp_r       <= '0;
            ma          <= '0;
            mb          <= '0;
            sum_r       <= '0;
            mn          <= '0;
            en          <= '0;
            zero_r      <= 1'b0;
            result_r    <= '0;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (state == IDLE && io.in_valid) begin
                op_a        <= io.a;
                op_b        <= io.b ^ {io.sub, {(W-1){1'b0}}};
                overflow_r  <= 1'b0;
                underflow_r <= 1'b0;
            end
            if (state == ALIGN) begin
                special <= spec;
                spec_r  <= spec_v;
                sign_r  <= big_s;
                eff_sub <= sa ^ sb;
                exp_r   <= big_e;
                ma      <= {1'b1, big_f, 3'b000};
                mb      <= sml_sh;
            end
            if (state == ADD) sum_r <= sum;
            if (state == NORM) begin
                mn     <= nm;
                en     <= ne;
                zero_r <= sum_r == '0;
            end
            if (state == ROUND) begin
                result_r    <= res_v;
                overflow_r  <= !special && !zero_r && !uf && of;
                underflow_r <= !special && !zero_r && uf;
            end
        end
    end
endmodule

// File: tb/tb_fp_add_seq.sv
// tb_fp_add_seq: directed self-checking bench for fp_add_seq (both rounding modes)
module tb_fp_add_seq;
    logic clk = 1'b0;
    logic clr = 1'b1;
    int   pass  = 0;
    int   total = 0;

    fp_add_seq_if if0 ();
    fp_add_seq_if if1 ();

    fp_add_seq #(.ROUND_MODE(0)) dut0 (.clk(clk), .clr(clr), .io(if0));
    fp_add_seq #(.ROUND_MODE(1)) dut1 (.clk(clk), .clr(clr), .io(if1));

    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic [31:0] xa, input logic [31:0] xb, input logic xs);
        if0.in_valid = v; if0.a = xa; if0.b = xb; if0.sub = xs;
        if1.in_valid = v; if1.a = xa; if1.b = xb; if1.sub = xs;
    endtask

    task automatic set_ready(input logic r);
        if0.out_ready = r;
        if1.out_ready = r;
    endtask

    // One full transaction on both instances; fl = {ov0, uf0, ov1, uf1}.
    task automatic run_op(input logic [31:0] xa, input logic [31:0] xb, input logic xs,
                          output logic [31:0] r0, output logic [31:0] r1,
                          output logic [3:0] fl, output int lat);
        @(negedge clk);
        drive(1'b1, xa, xb, xs);
        @(posedge clk); #1;
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        lat = 0;
        while (!if0.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        r0 = if0.result;
        r1 = if1.result;
        fl = {if0.overflow, if0.underflow, if1.overflow, if1.underflow};
        set_ready(1'b1);
        @(posedge clk); #1;
        set_ready(1'b0);
    endtask

    task automatic test_reset;
        #3;
        total++; if (if0.in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", if0.in_ready); else pass++;
        total++; if (if0.out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", if0.out_valid); else pass++;
        total++; if (if0.result !== 32'h0) $display("FAIL reset_result got %h want 00000000", if0.result); else pass++;
        total++; if ({if0.overflow, if0.underflow, if1.overflow, if1.underflow} !== 4'b0)
            $display("FAIL reset_flags got %b want 0000", {if0.overflow, if0.underflow, if1.overflow, if1.underflow}); else pass++;
        total++; if (if1.in_ready !== 1'b1 || if1.out_valid !== 1'b0) $display("FAIL reset_rm1 got %b%b want 10", if1.in_ready, if1.out_valid); else pass++;
        repeat (2) @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic test_basic;
        logic [31:0] r0, r1; logic [3:0] fl; int lat;
        run_op(32'h3F800000, 32'h40000000, 1'b0, r0, r1, fl, lat);
        total++; if (lat !== 4) $display("FAIL basic_latency got %0d want 4", lat); else pass++;
        total++; if (r0 !== 32'h40400000) $display("FAIL basic_sum got %h want 40400000", r0); else pass++;
        total++; if (r1 !== 32'h40400000) $display("FAIL basic_sum_rm1 got %h want 40400000", r1); else pass++;
        total++; if (fl !== 4'b0) $display("FAIL basic_flags got %b want 0000", fl); else pass++;
        run_op(32'h40000000, 32'h3F800000, 1'b1, r0, r1, fl, lat);
        total++; if (r0 !== 32'h3F800000) $display("FAIL sub_norm got %h want 3F800000", r0); else pass++;
        run_op(32'h3F800000, 32'h40000000, 1'b1, r0, r1, fl, lat);
        total++; if (r0 !== 32'hBF800000) $display("FAIL sub_swap got %h want BF800000", r0); else pass++;
    endtask

    task automatic test_zero;
        logic [31:0] r0, r1; logic [3:0] fl; int lat;
        run_op(32'h3F800000, 32'h3F800000, 1'b1, r0, r1, fl, lat);
        total++; if (r0 !== 32'h0 || fl !== 4'b0) $display("FAIL cancel got %h/%b want 00000000/0000", r0, fl); else pass++;
        run_op(32'h80000000, 32'h80000000, 1'b0, r0, r1, fl, lat);
        total++; if (r0 !== 32'h80000000) $display("FAIL neg_zero got %h want 80000000", r0); else pass++;
        run_op(32'h40490FDB, 32'h00000000, 1'b0, r0, r1, fl, lat);
        total++; if (r0 !== 32'h40490FDB) $display("FAIL x_plus_zero got %h want 40490FDB", r0); else pass++;
        run_op(32'h00000001, 32'h3F800000, 1'b0, r0, r1, fl, lat);
        total++; if (r0 !== 32'h3F800000) $display("FAIL denorm_ftz got %h want 3F800000", r0); else pass++;
    endtask

    task automatic test_overflow;
        logic [31:0] r0, r1; logic [3:0] fl; int lat;
        run_op(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, r0, r1, fl, lat);
        total++; if (r0 !== 32'h7F800000) $display("FAIL ovf_rne got %h want 7F800000", r0); else pass++;
        total++; if (r1 !== 32'h7F7FFFFF) $display("FAIL ovf_trunc got %h want 7F7FFFFF", r1); else pass++;
        total++; if (fl !== 4'b1010) $display("FAIL ovf_flags got %b want 1010", fl); else pass++;
    endtask

    task automatic test_special;
        logic [31:0] r0, r1; logic [3:0] fl; int lat;
        run_op(32'h7F800000, 32'hFF800000, 1'b0, r0, r1, fl, lat);
        total++; if (r0 !== 32'h7FC00000 || fl !== 4'b0) $display("FAIL inf_minus_inf got %h/%b want 7FC00000/0000", r0, fl); else pass++;
        run_op(32'h7FC00001, 32'h3F800000, 1'b0, r0, r1, fl, lat);
        total++; if (r0 !== 32'h7FC00000) $display("FAIL nan_in got %h want 7FC00000", r0); else pass++;
        run_op(32'h7F800000, 32'h3F800000, 1'b0, r0, r1, fl, lat);
        total++; if (r0 !== 32'h7F800000 || fl !== 4'b0) $display("FAIL inf_finite got %h/%b want 7F800000/0000", r0, fl); else pass++;
        run_op(32'h7F800000, 32'hFF800000, 1'b1, r0, r1, fl, lat);
        total++; if (r0 !== 32'h7F800000) $display("FAIL inf_same_sign got %h want 7F800000", r0); else pass++;
    endtask

    task automatic test_round;
        logic [31:0] r0, r1; logic [3:0] fl; int lat;
        run_op(32'h3F800001, 32'h33800000, 1'b0, r0, r1, fl, lat);
        total++; if (r0 !== 32'h3F800002) $display("FAIL rne_tie got %h want 3F800002", r0); else pass++;
        total++; if (r1 !== 32'h3F800001) $display("FAIL trunc_tie got %h want 3F800001", r1); else pass++;
    endtask

    task automatic test_underflow;
        logic [31:0] r0, r1; logic [3:0] fl; int lat;
        run_op(32'h00800001, 32'h00800000, 1'b1, r0, r1, fl, lat);
        total++; if (r0 !== 32'h0) $display("FAIL uf_result got %h want 00000000", r0); else pass++;
        total++; if (fl !== 4'b0101) $display("FAIL uf_flags got %b want 0101", fl); else pass++;
    endtask

    task automatic test_stall_and_abort;
        int bad;
        logic [31:0] r0, r1; logic [3:0] fl; int lat;
        @(negedge clk);
        drive(1'b1, 32'h3F800000, 32'h40000000, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        repeat (4) @(posedge clk); #1;
        total++; if (if0.out_valid !== 1'b1) $display("FAIL stall_valid_rise got %b want 1", if0.out_valid); else pass++;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            total++;
            if (if0.out_valid !== 1'b1 || if0.in_ready !== 1'b0 || if0.result !== 32'h40400000 || if0.overflow !== 1'b0 || if0.underflow !== 1'b0)
                $display("FAIL stall_hold cyc %0d got v%b r%b %h o%b u%b want v1 r0 40400000 o0 u0",
                         i, if0.out_valid, if0.in_ready, if0.result, if0.overflow, if0.underflow);
            else pass++;
        end
        set_ready(1'b1);
        @(posedge clk); #1;
        set_ready(1'b0);
        total++; if (if0.out_valid !== 1'b0 || if0.in_ready !== 1'b1) $display("FAIL stall_release got v%b r%b want v0 r1", if0.out_valid, if0.in_ready); else pass++;
        @(negedge clk);
        drive(1'b1, 32'h3F800000, 32'h40000000, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        @(posedge clk);
        @(posedge clk); #2;
        clr = 1'b1;
        #1;
        total++; if (if0.out_valid !== 1'b0 || if0.in_ready !== 1'b1) $display("FAIL abort_now got v%b r%b want v0 r1", if0.out_valid, if0.in_ready); else pass++;
        total++; if (if0.result !== 32'h0) $display("FAIL abort_result got %h want 00000000", if0.result); else pass++;
        @(negedge clk);
        clr = 1'b0;
        bad = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (if0.out_valid !== 1'b0 || if1.out_valid !== 1'b0) bad++;
        end
        total++; if (bad != 0) $display("FAIL abort_no_result got %0d valid cycles want 0", bad); else pass++;
        run_op(32'h3F800000, 32'h40000000, 1'b0, r0, r1, fl, lat);
        total++; if (r0 !== 32'h40400000 || lat !== 4) $display("FAIL after_abort got %h lat %0d want 40400000 lat 4", r0, lat); else pass++;
    endtask

    initial begin
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        set_ready(1'b0);
        test_reset;
        test_basic;
        test_zero;
        test_overflow;
        test_special;
        test_round;
        test_underflow;
        test_stall_and_abort;
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
